// File: rtl/uart_pkg.sv
// Shared constants and types for the framed UART receiver family.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Width of a counter that must hold values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous, idle-high serial line.
module uart_rx_sync (
    input  logic clock,
    input  logic resetN,
    input  logic din_i,
    output logic rxs_o
);

    logic meta_q;
    logic rxs_q;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            meta_q <= 1'b1;
            rxs_q  <= 1'b1;
        end else begin
            meta_q <= din_i;
            rxs_q  <= meta_q;
        end
    end

    assign rxs_o = rxs_q;

endmodule

// File: rtl/uart_rx_framed.sv
// Framed UART receiver with mid-bit sampling, error flags and a valid/ready
// holding register.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_IDLE      | line idle, waiting for a low on rxs
//   ST_START     | half-bit wait, then confirm start bit (reject glitch)
//   ST_DATA      | sample DATA_BITS payload bits, LSB first
//   ST_PARITY    | sample and check the parity bit
//   ST_STOP      | sample STOP_BITS stop bits, request delivery at last
//   ST_WAIT_IDLE | last stop bit was low, wait for the line to go high
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 48,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clock,
    input  logic                 resetN,
    input  logic                 serialIn,
    input  logic                 rxReady,
    output logic [DATA_BITS-1:0] rxData,
    output logic                 rxValid,
    output logic                 parityError,
    output logic                 frameError,
    output logic                 overrun,
    output logic                 busy
);

    localparam int            CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
    localparam logic          LAST_STP = 1'(STOP_BITS - 1);

    logic rxs;

    uart_rx_sync u_sync (
        .clock (clock),
        .resetN(resetN),
        .din_i (serialIn),
        .rxs_o (rxs)
    );

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 deliver_q, deliver_d;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    logic tick;
    logic transfer;

    assign tick     = (cnt_q == '0);
    assign transfer = valid_q & rxReady;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        shreg_d    = shreg_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        deliver_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d   = ST_START;
                    cnt_d     = CNT_HALF;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (rxs) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d   = ST_DATA;
                    cnt_d     = CNT_FULL;
                    bit_idx_d = '0;
                end
            end
            ST_DATA: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = CNT_FULL;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d    = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        stop_idx_d = 1'b0;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Overall XOR is 1 for odd ones-count: an error for even mode.
                    par_err_d  = (^{shreg_q, rxs}) ^ (PARITY == PARITY_ODD);
                    state_d    = ST_STOP;
                    cnt_d      = CNT_FULL;
                    stop_idx_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (!tick) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    frm_err_d = frm_err_q | ~rxs;
                    if (stop_idx_q == LAST_STP) begin
                        deliver_d = 1'b1;
                        state_d   = rxs ? ST_IDLE : ST_WAIT_IDLE;
                    end else begin
                        stop_idx_d = 1'b1;
                        cnt_d      = CNT_FULL;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;

        if (deliver_q && (!valid_q || transfer)) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            perr_d  = par_err_q;
            ferr_d  = frm_err_q;
            ovr_d   = transfer ? 1'b0 : ovr_q;
        end else if (deliver_q) begin
            ovr_d = 1'b1;
        end else if (transfer) begin
            valid_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            deliver_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            shreg_q    <= shreg_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            deliver_q  <= deliver_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    assign rxData      = data_q;
    assign rxValid     = valid_q;
    assign parityError = perr_q;
    assign frameError  = ferr_q;
    assign overrun     = ovr_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: doc/uart_rx_framed.md
Name: uart_rx_framed

Overview:
Parametrised serial receiver, next generation of the UART RX used in the ADC demo.
- Configurable data width, parity mode and stop-bit count.
- Mid-bit sampling through an input synchroniser, with false-start rejection.
- Framing, parity and overrun error reporting.
- Output is a single-entry holding register with a valid/ready handshake toward the consuming logic (command parser, FIFO).

Parameters:
- CLKS_PER_BIT, 48, clock cycles per bit period; legal range ≥ 4.
- DATA_BITS, 8, payload bits per frame, 5..9, LSB first.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, 1 or 2.

Ports:
- clock  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- serialIn  in  1  asynchronous RX line, idle high
- rxReady  in  1  consumer accepts rxData this cycle
- rxData  out  DATA_BITS  received payload
- rxValid  out  1  rxData and the error flags are valid
- parityError  out  1  parity mismatch for the presented frame
- frameError  out  1  a stop bit was sampled low for the presented frame
- overrun  out  1  one or more frames were dropped while rxValid was held
- busy  out  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset: asynchronous on resetN low.
  - All outputs are 0; synchroniser flops are 1; state is IDLE; counters are 0.
  - Reset mid-frame abandons the frame; no partial data is ever presented.
- Synchroniser: two flops on serialIn; the FSM sees rxs, which lags serialIn by 2 cycles.
- Baud counter:
  - Width is clog2(CLKS_PER_BIT).
  - Loaded with CLKS_PER_BIT-1 on each bit boundary; one sample is taken when it reaches 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: rxs == 0 → START, counter = CLKS_PER_BIT/2 - 1.
  - START: sample at counter 0.
    - Sample 1 → IDLE (glitch rejected, no output).
    - Sample 0 → DATA, bitIdx = 0.
  - DATA: shift the sample in LSB first; after bit DATA_BITS-1 → PARITY if PARITY != 0, else STOP.
  - PARITY: sample, then compare.
    - Odd: XOR(data, parity bit) must be 1.
    - Even: XOR(data, parity bit) must be 0.
    - Result is latched into an internal flag.
  - STOP: sample STOP_BITS stop bits.
    - Any stop sample of 0 sets the internal frame-error flag.
    - After the last stop sample, the frame is delivered (see below).
    - Next state is IDLE if the last sample was 1, else WAIT_IDLE.
  - WAIT_IDLE: stay until rxs == 1, then → IDLE. Break or stuck-low does not produce repeated frames.
- Delivery: occurs in the cycle after the last stop-bit sample.
  - If rxValid == 0, or rxValid && rxReady in that cycle:
    - Load rxData, parityError and frameError.
    - Set rxValid = 1.
    - Set overrun = 0 if a transfer occurs this cycle, else keep overrun.
  - Else (rxValid held, not consumed):
    - Drop the new frame; rxData and the error flags keep the old frame.
    - Set overrun = 1 (sticky).
- Handshake:
  - A transfer occurs when rxValid && rxReady.
  - rxValid drops the next cycle unless a delivery happens in the same cycle.
  - A delivery coinciding with a transfer keeps rxValid = 1 and is not an overrun.
- Error-flag lifetime:
  - parityError and frameError are only meaningful while rxValid = 1.
  - On a transfer without a coinciding delivery, both clear to 0, and overrun clears to 0.
- Frames with errors are still delivered (data + flag); the consumer decides what to do with them.
- Latency: rxValid rises at (1 + DATA_BITS + P + STOP_BITS - 0.5)·CLKS_PER_BIT + 3 cycles (±1) after the serialIn falling edge, where P = 1 if PARITY != 0, else 0.

Decomposition:
- Package uart_pkg:
  - Parity constants: PARITY_NONE = 0, PARITY_ODD = 1, PARITY_EVEN = 2.
  - RX state enum.
  - Helper function for counter width (clog2).
- Sub-module uart_rx_sync: two-flop synchroniser with reset value 1, output rxs.
  - Shared with future TX loopback and other asynchronous inputs.
- FSM, baud counter, shifter and holding register stay in uart_rx_framed.

Test Plan:
- 8N1, CLKS_PER_BIT = 16, send 0x55 with rxReady = 1.
  - rxData = 0x55, rxValid pulses 1 cycle about 155 clocks after the start edge.
  - parityError = 0, frameError = 0.
- Glitch: serialIn low for 3 clocks, then high.
  - busy pulses, rxValid never asserts, FSM returns to IDLE.
- PARITY = 2 (even), 8 data bits, send 0xA3 with parity bit 1 (wrong; correct is 0).
  - rxData = 0xA3, parityError = 1.
  - Repeat with parity bit 0 → parityError = 0.
- STOP_BITS = 2, send 0x3C with second stop bit 0, then hold the line low 5 bit-times.
  - rxData = 0x3C, frameError = 1.
  - No further rxValid while low; a frame sent after the line returns high is received correctly.
- Overrun: rxReady = 0, send 0x11 then 0x22.
  - rxData stays 0x11, overrun = 1.
  - Assert rxReady for 1 cycle → transfer; rxValid = 0 and overrun = 0 next cycle.
  - Sending 0x33 then → rxData = 0x33.
- Reset: assert resetN = 0 mid-DATA of 0x7E.
  - All outputs 0 immediately (asynchronous).
  - After release with the line idle: no rxValid; the next frame 0x81 is received intact.
